perm_sort_seq: RTL and testbench
================================

PERM_SORT_SEQ -- requirements
Module: perm_sort_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, flit data width.
REQ-002 SHALL have parameter NUM_PORT, default 4, productive-port-vector width.
REQ-003 SHALL have parameter TIME_WIDTH, default 8, timestamp width.
REQ-004 SHALL have parameter TIME_LSB, default 0, timestamp LSB position inside data.
REQ-005 SHALL have parameter FULL_SORT, default 0; 0 = oldest-first partial sort, 1 = full age sort.
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have ports in_data0..in_data3  input  DATA_WIDTH each  candidate flits.
REQ-009 SHALL have ports in_ppv0..in_ppv3  input  NUM_PORT each  productive port vectors.
REQ-010 SHALL have port in_vld  input  4  per-flit valid; bit i qualifies flit i.
REQ-011 SHALL have port in_valid / in_ready  input / output  1 each  request handshake.
REQ-012 SHALL have ports rank0_data..rank3_data  output  DATA_WIDTH each  sorted flits.
REQ-013 SHALL have ports rank0_ppv..rank3_ppv  output  NUM_PORT each  sorted PPVs.
REQ-014 SHALL have port rank_vld  output  4  per-rank flit valid.
REQ-015 SHALL have port out_valid / out_ready  output / input  1 each  result handshake.
REQ-016 SHALL have port busy  output  1  high whenever not in IDLE.
REQ-017 SHALL have port swap_cnt  output  3  number of swaps performed for the current result.

Function
REQ-018 SHALL contain exactly one compare-swap unit, time-shared, one compare per cycle over working registers r0..r3 (data, ppv, vld).
REQ-019 SHALL implement FSM IDLE -> CMP -> OUT -> IDLE; in_ready = 1 only in IDLE; busy = (state != IDLE).
REQ-020 SHALL, in IDLE on in_valid && in_ready, load r0..r3 from flits 0..3, clear swap_cnt and step counter, and enter CMP.
REQ-021 SHALL execute compare sequence: step0 (r0,r1) older->r0; step1 (r2,r3) older->r3; step2 (r0,r3) older->r0; step3 (r1,r2) older->r1; when FULL_SORT=1, step4 (r1,r3) older->r1.
REQ-022 SHALL define older: valid beats invalid; both valid -> smaller unsigned timestamp (data[TIME_LSB+:TIME_WIDTH]); ties and both-invalid -> no swap.
REQ-023 SHALL perform no wrap-around timestamp correction.
REQ-024 SHALL increment swap_cnt on each swap; swap_cnt saturates at 7.
REQ-025 SHALL enter OUT after the final step and assert out_valid: accept at edge T -> out_valid high after edge T+4 (FULL_SORT=0) or T+5 (FULL_SORT=1).
REQ-026 SHALL map ranks r0,r1,r2,r3 -> rank0..rank3 when FULL_SORT=0, and r0,r1,r3,r2 -> rank0..rank3 when FULL_SORT=1.
REQ-027 SHALL hold all rank outputs, rank_vld, swap_cnt and out_valid stable while out_valid && !out_ready.
REQ-028 SHALL, on out_valid && out_ready, return to IDLE; in_ready rises the following cycle (no same-cycle reload).
REQ-029 SHALL ignore in_valid outside IDLE; inputs are sampled only on the accepting edge.
REQ-030 SHALL drive rank outputs only from registers (no combinational input-to-output path).

Reset
REQ-031 SHALL, on reset low, asynchronously enter IDLE and clear r0..r3, step counter, swap_cnt, out_valid, rank_vld and all rank outputs to 0; in_ready = 1, busy = 0.
REQ-032 SHALL abandon any in-progress sort on reset, with no result emitted after release.

Verification
REQ-033 SHALL cover: FULL_SORT=0, all valid, ts {30,10,40,20} -> out_valid at T+4, rank ts {10,30,40,20}, swap_cnt=1.
REQ-034 SHALL cover: FULL_SORT=1, same input -> out_valid at T+5, rank ts {10,20,30,40}, swap_cnt=2.
REQ-035 SHALL cover: all ts=5, all valid -> ranks equal inputs in order 0..3, swap_cnt=0.
REQ-036 SHALL cover: in_vld=4'b1000, flit3 ts=200, others ts=0 -> rank0=flit3, rank_vld[0]=1, swap_cnt=1.
REQ-037 SHALL cover: out_ready low 3 cycles in OUT -> outputs unchanged, in_ready=0; then out_ready high -> IDLE, in_ready=1 next cycle.
REQ-038 SHALL cover: reset asserted during step2 -> all outputs 0 immediately, in_ready=1, no out_valid after release until a new accept.

Source files
------------

// File: rtl/perm_sort_seq.sv
// Time-shared compare-swap sorter: ranks four flits by age (oldest first).
// Ports: 4 flits+ppv+vld in (valid/ready), 4 ranked flits out (valid/ready), busy, swap_cnt.
module perm_sort_seq #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PORT   = 4,
  parameter int TIME_WIDTH = 8,
  parameter int TIME_LSB   = 0,
  parameter int FULL_SORT  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data0,
  input  logic [DATA_WIDTH-1:0] in_data1,
  input  logic [DATA_WIDTH-1:0] in_data2,
  input  logic [DATA_WIDTH-1:0] in_data3,
  input  logic [NUM_PORT-1:0]   in_ppv0,
  input  logic [NUM_PORT-1:0]   in_ppv1,
  input  logic [NUM_PORT-1:0]   in_ppv2,
  input  logic [NUM_PORT-1:0]   in_ppv3,
  input  logic [3:0]            in_vld,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] rank0_data,
  output logic [DATA_WIDTH-1:0] rank1_data,
  output logic [DATA_WIDTH-1:0] rank2_data,
  output logic [DATA_WIDTH-1:0] rank3_data,
  output logic [NUM_PORT-1:0]   rank0_ppv,
  output logic [NUM_PORT-1:0]   rank1_ppv,
  output logic [NUM_PORT-1:0]   rank2_ppv,
  output logic [NUM_PORT-1:0]   rank3_ppv,
  output logic [3:0]            rank_vld,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [2:0]            swap_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [2:0] LAST_STEP =
    (FULL_SORT != 0) ? 3'd4 : 3'd3;

  logic [1:0]            state_q, state_d;
  logic [2:0]            step_q, step_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] r_data_q [4];
  logic [DATA_WIDTH-1:0] r_data_d [4];
  logic [NUM_PORT-1:0]   r_ppv_q [4];
  logic [NUM_PORT-1:0]   r_ppv_d [4];
  logic [3:0]            r_vld_q, r_vld_d;

  logic [1:0]            ia, ib;
  logic [TIME_WIDTH-1:0] a_ts, b_ts;
  logic                  do_swap;

  // Slot ia receives the older flit of the pair.
  always_comb begin
    ia = 2'd1;
    ib = 2'd3;
    unique case (step_q)
      3'd0: begin ia = 2'd0; ib = 2'd1; end
      3'd1: begin ia = 2'd3; ib = 2'd2; end
      3'd2: begin ia = 2'd0; ib = 2'd3; end
      3'd3: begin ia = 2'd1; ib = 2'd2; end
      default: begin ia = 2'd1; ib = 2'd3; end
    endcase
  end

  assign a_ts = r_data_q[ia][TIME_LSB +: TIME_WIDTH];
  assign b_ts = r_data_q[ib][TIME_LSB +: TIME_WIDTH];

  // Ties and both-invalid keep the current order.
  assign do_swap = r_vld_q[ib] &&
                   (!r_vld_q[ia] || (b_ts < a_ts));

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    r_data_d = r_data_q;
    r_ppv_d  = r_ppv_q;
    r_vld_d  = r_vld_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (in_valid) begin
          r_data_d[0] = in_data0;
          r_data_d[1] = in_data1;
          r_data_d[2] = in_data2;
          r_data_d[3] = in_data3;
          r_ppv_d[0]  = in_ppv0;
          r_ppv_d[1]  = in_ppv1;
          r_ppv_d[2]  = in_ppv2;
          r_ppv_d[3]  = in_ppv3;
          r_vld_d     = in_vld;
          step_d      = 3'd0;
          cnt_d       = 3'd0;
          state_d     = S_CMP;
        end
      end
      (state_q == S_CMP): begin
        if (do_swap) begin
          r_data_d[ia] = r_data_q[ib];
          r_data_d[ib] = r_data_q[ia];
          r_ppv_d[ia]  = r_ppv_q[ib];
          r_ppv_d[ib]  = r_ppv_q[ia];
          r_vld_d[ia]  = r_vld_q[ib];
          r_vld_d[ib]  = r_vld_q[ia];
          if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
        end
        step_d = step_q + 3'd1;
        if (step_q == LAST_STEP) state_d = S_OUT;
      end
      (state_q == S_OUT): begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      step_q  <= 3'd0;
      cnt_q   <= 3'd0;
      r_vld_q <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        r_data_q[i] <= '0;
        r_ppv_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      r_vld_q  <= r_vld_d;
      r_data_q <= r_data_d;
      r_ppv_q  <= r_ppv_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign swap_cnt  = cnt_q;

  // Full sort leaves the third-oldest flit in r3.
  if (FULL_SORT != 0) begin : g_full
    assign rank2_data = r_data_q[3];
    assign rank3_data = r_data_q[2];
    assign rank2_ppv  = r_ppv_q[3];
    assign rank3_ppv  = r_ppv_q[2];
    assign rank_vld   = {r_vld_q[2], r_vld_q[3],
                         r_vld_q[1], r_vld_q[0]};
  end else begin : g_part
    assign rank2_data = r_data_q[2];
    assign rank3_data = r_data_q[3];
    assign rank2_ppv  = r_ppv_q[2];
    assign rank3_ppv  = r_ppv_q[3];
    assign rank_vld   = r_vld_q;
  end

  assign rank0_data = r_data_q[0];
  assign rank1_data = r_data_q[1];
  assign rank0_ppv  = r_ppv_q[0];
  assign rank1_ppv  = r_ppv_q[1];

endmodule

// File: tb/tb_perm_sort_seq.sv
// Bench for perm_sort_seq: partial and full sort instances side by side.
// Directed vectors with hand-derived rank orders, latency, hold and reset.
module tb_perm_sort_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]  in_ppv0, in_ppv1, in_ppv2, in_ppv3;
  logic [3:0]  in_vld;
  logic        in_valid;
  logic        out_ready;

  logic        ir0, ir1, ov0, ov1, bz0, bz1;
  logic [63:0] rd0 [4];
  logic [63:0] rd1 [4];
  logic [3:0]  rp0 [4];
  logic [3:0]  rp1 [4];
  logic [3:0]  rv0, rv1;
  logic [2:0]  sc0, sc1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  perm_sort_seq #(.FULL_SORT(0)) dut0 (
    .clk(clk), .reset(reset),
    .in_data0(in_data0), .in_data1(in_data1),
    .in_data2(in_data2), .in_data3(in_data3),
    .in_ppv0(in_ppv0), .in_ppv1(in_ppv1),
    .in_ppv2(in_ppv2), .in_ppv3(in_ppv3),
    .in_vld(in_vld), .in_valid(in_valid),
    .in_ready(ir0),
    .rank0_data(rd0[0]), .rank1_data(rd0[1]),
    .rank2_data(rd0[2]), .rank3_data(rd0[3]),
    .rank0_ppv(rp0[0]), .rank1_ppv(rp0[1]),
    .rank2_ppv(rp0[2]), .rank3_ppv(rp0[3]),
    .rank_vld(rv0), .out_valid(ov0),
    .out_ready(out_ready), .busy(bz0),
    .swap_cnt(sc0)
  );

  perm_sort_seq #(.FULL_SORT(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_data0(in_data0), .in_data1(in_data1),
    .in_data2(in_data2), .in_data3(in_data3),
    .in_ppv0(in_ppv0), .in_ppv1(in_ppv1),
    .in_ppv2(in_ppv2), .in_ppv3(in_ppv3),
    .in_vld(in_vld), .in_valid(in_valid),
    .in_ready(ir1),
    .rank0_data(rd1[0]), .rank1_data(rd1[1]),
    .rank2_data(rd1[2]), .rank3_data(rd1[3]),
    .rank0_ppv(rp1[0]), .rank1_ppv(rp1[1]),
    .rank2_ppv(rp1[2]), .rank3_ppv(rp1[3]),
    .rank_vld(rv1), .out_valid(ov1),
    .out_ready(out_ready), .busy(bz1),
    .swap_cnt(sc1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int i,
                                     input logic [7:0] t);
    return (64'(i + 1) << 56) | 64'(t);
  endfunction

  task automatic drive(input logic [31:0] ts,
                       input logic [3:0] vld);
    in_data0 = mk(0, ts[7:0]);
    in_data1 = mk(1, ts[15:8]);
    in_data2 = mk(2, ts[23:16]);
    in_data3 = mk(3, ts[31:24]);
    in_ppv0  = 4'b0001;
    in_ppv1  = 4'b0010;
    in_ppv2  = 4'b0100;
    in_ppv3  = 4'b1000;
    in_vld   = vld;
  endtask

  // ordN: rank k holds flit ordN[2k+:2]
  task automatic run_case(input string nm,
                          input logic [31:0] ts,
                          input logic [3:0] vld,
                          input logic [7:0] ord0,
                          input logic [7:0] ord1,
                          input logic [2:0] c0,
                          input logic [2:0] c1,
                          input logic [3:0] v0,
                          input logic [3:0] v1);
    int lat0;
    int lat1;
    int ix;
    logic [63:0] e0;
    @(negedge clk);
    drive(ts, vld);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk({nm, ".busy"}, 64'(bz0), 64'd1);
    chk({nm, ".in_ready_busy"}, 64'(ir0), 64'd0);
    lat0 = 0;
    lat1 = 0;
    for (int k = 1; k <= 10 && (lat0 == 0 || lat1 == 0); k++) begin
      @(posedge clk);
      #1;
      if (ov0 && lat0 == 0) lat0 = k;
      if (ov1 && lat1 == 0) lat1 = k;
    end
    chk({nm, ".lat_part"}, 64'(lat0), 64'd4);
    chk({nm, ".lat_full"}, 64'(lat1), 64'd5);
    for (int k = 0; k < 4; k++) begin
      ix = int'(ord0[2*k +: 2]);
      chk($sformatf("%s.p_data%0d", nm, k), rd0[k],
          mk(ix, ts[8*ix +: 8]));
      chk($sformatf("%s.p_ppv%0d", nm, k), 64'(rp0[k]),
          64'(4'b0001 << ix));
      ix = int'(ord1[2*k +: 2]);
      chk($sformatf("%s.f_data%0d", nm, k), rd1[k],
          mk(ix, ts[8*ix +: 8]));
    end
    chk({nm, ".p_vld"}, 64'(rv0), 64'(v0));
    chk({nm, ".f_vld"}, 64'(rv1), 64'(v1));
    chk({nm, ".p_cnt"}, 64'(sc0), 64'(c0));
    chk({nm, ".f_cnt"}, 64'(sc1), 64'(c1));
    ix = int'(ord0[1:0]);
    e0 = mk(ix, ts[8*ix +: 8]);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk({nm, ".hold_ov"}, 64'(ov0), 64'd1);
      chk({nm, ".hold_r0"}, rd0[0], e0);
      chk({nm, ".hold_cnt"}, 64'(sc0), 64'(c0));
      chk({nm, ".hold_ir"}, 64'(ir0), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({nm, ".p_idle"}, 64'(ir0), 64'd1);
    chk({nm, ".f_idle"}, 64'(ir1), 64'd1);
    chk({nm, ".p_ov_off"}, 64'(ov0), 64'd0);
    chk({nm, ".p_busy_off"}, 64'(bz0), 64'd0);
  endtask

  initial begin
    logic seen;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(32'h0, 4'h0);
    #12;
    chk("rst.in_ready", 64'(ir0), 64'd1);
    chk("rst.busy", 64'(bz0), 64'd0);
    chk("rst.ov", 64'(ov0), 64'd0);
    chk("rst.r0", rd0[0], 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // ts {30,10,40,20}
    run_case("mix", {8'd20, 8'd40, 8'd10, 8'd30}, 4'hf,
             {2'd3, 2'd2, 2'd0, 2'd1},
             {2'd2, 2'd0, 2'd3, 2'd1},
             3'd1, 3'd2, 4'hf, 4'hf);
    // all ties: no movement
    run_case("tie", {8'd5, 8'd5, 8'd5, 8'd5}, 4'hf,
             {2'd3, 2'd2, 2'd1, 2'd0},
             {2'd2, 2'd3, 2'd1, 2'd0},
             3'd0, 3'd0, 4'hf, 4'hf);
    // only flit3 valid
    run_case("one", {8'd200, 8'd0, 8'd0, 8'd0}, 4'b1000,
             {2'd0, 2'd2, 2'd1, 2'd3},
             {2'd2, 2'd0, 2'd1, 2'd3},
             3'd1, 3'd1, 4'b0001, 4'b0001);

    // reset while step2 is in flight
    @(negedge clk);
    drive({8'd20, 8'd40, 8'd10, 8'd30}, 4'hf);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid.cnt_before", 64'(sc0), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid.r0", rd0[0], 64'd0);
    chk("mid.r3", rd0[3], 64'd0);
    chk("mid.f_r0", rd1[0], 64'd0);
    chk("mid.vld", 64'(rv0), 64'd0);
    chk("mid.cnt", 64'(sc0), 64'd0);
    chk("mid.ov", 64'(ov0), 64'd0);
    chk("mid.in_ready", 64'(ir0), 64'd1);
    chk("mid.busy", 64'(bz1), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ov0 || ov1 || bz0 || bz1) seen = 1'b1;
    end
    chk("mid.no_result", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
